// File: rtl/s_subt.sv
// Registered unsigned A - B subtractor with borrow/zero/valid flags.
// Define S_SUBT_SAT_EN to clamp underflowing results to zero.
module s_subt #(
   parameter int P = 8
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         EN,
   input  logic [P-1:0] A,
   input  logic [4:0]   B,
   output logic [P-1:0] Y,
   output logic         BORROW,
   output logic         ZERO,
   output logic         VALID
);

   logic [P:0]   d;
   logic [P-1:0] res;

   assign d = {1'b0, A} - {{(P-4){1'b0}}, B};

`ifdef S_SUBT_SAT_EN
   assign res = d[P] ? '0 : d[P-1:0];
`else
   assign res = d[P-1:0];
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         Y      <= '0;
         BORROW <= 1'b0;
         ZERO   <= 1'b1;
         VALID  <= 1'b0;
      end else begin
         VALID <= EN;
         if (EN) begin
            Y      <= res;
            BORROW <= d[P];
            ZERO   <= (res == '0);
         end
      end
   end

endmodule

// File: tb/tb_s_subt.sv
// Self-checking bench for s_subt: directed plan steps plus random
// traffic checked against an integer-arithmetic reference model.
module tb_s_subt;

   localparam int P = 8;

   logic         CLK = 1'b0;
   logic         RST = 1'b0;
   logic         EN = 1'b0;
   logic [P-1:0] A = '0;
   logic [4:0]   B = '0;
   logic [P-1:0] Y;
   logic         BORROW;
   logic         ZERO;
   logic         VALID;

   int checks = 0;
   int failures = 0;

   logic [P-1:0] exp_y = '0;
   logic         exp_b = 1'b0;
   logic         exp_z = 1'b1;
   logic         exp_v = 1'b0;

   s_subt #(.P(P)) dut (
      .CLK(CLK), .RST(RST), .EN(EN),
      .A(A), .B(B), .Y(Y),
      .BORROW(BORROW), .ZERO(ZERO),
      .VALID(VALID)
   );

   always #5 CLK = ~CLK;

   task automatic model_reset();
      exp_y = '0;
      exp_b = 1'b0;
      exp_z = 1'b1;
      exp_v = 1'b0;
   endtask

   task automatic model_step(
      input logic en, input int a, input int b
   );
      int diff;
      int r;
      exp_v = en;
      if (en) begin
         diff = a - b;
`ifdef S_SUBT_SAT_EN
         r = (diff < 0) ? 0 : diff;
`else
         r = (diff + (1 << P)) % (1 << P);
`endif
         exp_y = r[P-1:0];
         exp_b = (diff < 0);
         exp_z = (r == 0);
      end
   endtask

   task automatic check_all(input string tag);
      checks++;
      assert (Y === exp_y) else begin
         failures++;
         $error("FAIL %s y got=%0d want=%0d", tag, Y, exp_y);
      end
      checks++;
      assert (BORROW === exp_b) else begin
         failures++;
         $error("FAIL %s borrow got=%b want=%b",
                tag, BORROW, exp_b);
      end
      checks++;
      assert (ZERO === exp_z) else begin
         failures++;
         $error("FAIL %s zero got=%b want=%b",
                tag, ZERO, exp_z);
      end
      checks++;
      assert (VALID === exp_v) else begin
         failures++;
         $error("FAIL %s valid got=%b want=%b",
                tag, VALID, exp_v);
      end
   endtask

   task automatic apply(
      input string tag, input logic en,
      input int a, input int b
   );
      EN = en;
      A = a[P-1:0];
      B = b[4:0];
      @(posedge CLK);
      model_step(en, a, b);
      #1;
      check_all(tag);
   endtask

   initial begin
      #1 RST = 1'b1;
      #1;
      model_reset();
      check_all("reset");
      @(posedge CLK);
      #1 RST = 1'b0;
      check_all("reset_hold");

      apply("equal", 1'b1, 4, 4);
      apply("basic", 1'b1, 11, 2);
      apply("under", 1'b1, 3, 5);
      apply("b_zero", 1'b1, 173, 0);
      apply("a_max", 1'b1, 255, 31);
      apply("a_zero", 1'b1, 0, 31);
      apply("idle", 1'b0, 0, 0);

      apply("hold_en", 1'b1, 200, 31);
      for (int i = 0; i < 3; i++)
         apply("hold", 1'b0, $urandom_range(255),
               $urandom_range(31));

      #2 RST = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      @(posedge CLK);
      #1 RST = 1'b0;
      apply("post_rst", 1'b0, 77, 3);

      apply("stream0", 1'b1, 10, 1);
      apply("stream1", 1'b1, 20, 2);
      apply("stream2", 1'b1, 30, 3);
      apply("stream3", 1'b1, 40, 4);

      for (int i = 0; i < 300; i++) begin
         int a;
         int b;
         logic en;
         en = ($urandom_range(3) != 0);
         a = (i % 7 == 0) ? $urandom_range(31)
                          : $urandom_range(255);
         b = $urandom_range(31);
         if (i % 11 == 0) a = b;
         apply("rand", en, a, b);
      end

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
